// File: rtl/mcpu_core_icache.sv
// Direct-mapped read-only instruction cache. Hits answer in the same cycle;
// misses fill one line through a single-outstanding memory read port.
module mcpu_core_icache #(
  parameter int SETS_LOG2 = 6
) (
  input  logic         clkrst_core_clk,
  input  logic         clkrst_core_rst,
  input  logic         f2ic_valid,
  input  logic [27:0]  f2ic_paddr,
  output logic         ic2f_ready,
  output logic [127:0] ic2f_packet,
  input  logic         ic_inval,
  output logic         ic2mem_valid,
  output logic [27:0]  ic2mem_addr,
  input  logic         mem2ic_ready,
  input  logic         mem2ic_data_valid,
  input  logic [127:0] mem2ic_data
);
  localparam int LINES = 1 << SETS_LOG2;
  localparam int TAG_W = 28 - SETS_LOG2;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t                 state_q, state_d;
  logic [27:0]            fill_addr_q, fill_addr_d;
  logic                   drop_q, drop_d;
  logic [LINES-1:0]       valid_q, valid_d;
  logic [TAG_W-1:0]       tag_q  [LINES];
  logic [127:0]           data_q [LINES];

  logic [SETS_LOG2-1:0]   idx, fill_idx;
  logic [TAG_W-1:0]       tag;
  logic                   hit, fill_we;

  assign idx      = f2ic_paddr[SETS_LOG2-1:0];
  assign tag      = f2ic_paddr[27:SETS_LOG2];
  assign fill_idx = fill_addr_q[SETS_LOG2-1:0];

  assign hit         = f2ic_valid & valid_q[idx] & (tag_q[idx] == tag) &
                       (state_q == S_IDLE) & ~ic_inval;
  assign ic2f_ready  = hit;
  assign ic2f_packet = hit ? data_q[idx] : 128'd0;
  assign fill_we     = (state_q == S_WAIT) & mem2ic_data_valid;

  always_comb begin
    state_d      = state_q;
    fill_addr_d  = fill_addr_q;
    drop_d       = drop_q;
    valid_d      = valid_q;
    ic2mem_valid = 1'b0;
    ic2mem_addr  = 28'd0;
    case (state_q)
      S_IDLE: begin
        if (f2ic_valid && !hit && !ic_inval) begin
          fill_addr_d = f2ic_paddr;
          state_d     = S_REQ;
        end
      end
      S_REQ: begin
        ic2mem_valid = 1'b1;
        ic2mem_addr  = fill_addr_q;
        if (mem2ic_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mem2ic_data_valid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // An invalidate seen mid-fill poisons the line being fetched.
    if (ic_inval && state_q != S_IDLE) drop_d = 1'b1;
    if (fill_we) begin
      drop_d            = 1'b0;
      valid_d[fill_idx] = ~drop_q;
    end
    if (ic_inval) valid_d = '0;
  end

  always_ff @(posedge clkrst_core_clk or posedge clkrst_core_rst) begin
    if (clkrst_core_rst) begin
      state_q     <= S_IDLE;
      fill_addr_q <= 28'd0;
      drop_q      <= 1'b0;
      valid_q     <= '0;
    end else begin
      state_q     <= state_d;
      fill_addr_q <= fill_addr_d;
      drop_q      <= drop_d;
      valid_q     <= valid_d;
    end
  end

  // Tag and data storage is qualified by valid bits, so it carries no reset.
  always_ff @(posedge clkrst_core_clk) begin
    if (fill_we) begin
      tag_q[fill_idx]  <= fill_addr_q[27:SETS_LOG2];
      data_q[fill_idx] <= mem2ic_data;
    end
  end
endmodule

// File: tb/tb_mcpu_core_icache.sv
// Directed bench for mcpu_core_icache: cold miss, hit, backpressure,
// conflict eviction, invalidate during fill, inval-cycle ready, reset mid-fill.
module tb_mcpu_core_icache;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         f2ic_valid = 1'b0;
  logic [27:0]  f2ic_paddr = 28'd0;
  logic         ic2f_ready;
  logic [127:0] ic2f_packet;
  logic         ic_inval = 1'b0;
  logic         ic2mem_valid;
  logic [27:0]  ic2mem_addr;
  logic         mem2ic_ready = 1'b0;
  logic         mem2ic_data_valid = 1'b0;
  logic [127:0] mem2ic_data = 128'd0;

  int pass_cnt = 0;
  int total_cnt = 0;

  localparam logic [127:0] D_A5 = 128'h0123_4567_89ab_cdef_0011_2233_4455_66a5;
  localparam logic [127:0] D_B6 = 128'hfeed_face_0bad_f00d_1357_9bdf_2468_aab6;
  localparam logic [127:0] D_C7 = 128'h7777_0000_3333_1111_cccc_eeee_5555_99c7;
  localparam logic [127:0] D_D8 = 128'h0f0f_1e1e_2d2d_3c3c_4b4b_5a5a_6969_78d8;
  localparam logic [127:0] D_E9 = 128'haaaa_5555_aaaa_5555_1234_4321_abcd_dce9;

  mcpu_core_icache #(.SETS_LOG2(6)) dut (
    .clkrst_core_clk  (clk),
    .clkrst_core_rst  (rst),
    .f2ic_valid       (f2ic_valid),
    .f2ic_paddr       (f2ic_paddr),
    .ic2f_ready       (ic2f_ready),
    .ic2f_packet      (ic2f_packet),
    .ic_inval         (ic_inval),
    .ic2mem_valid     (ic2mem_valid),
    .ic2mem_addr      (ic2mem_addr),
    .mem2ic_ready     (mem2ic_ready),
    .mem2ic_data_valid(mem2ic_data_valid),
    .mem2ic_data      (mem2ic_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string t, input logic [127:0] obs, input logic [127:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", t, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a missing address and serve the fill after 'stall' refused cycles.
  task automatic do_fill(input logic [27:0] a, input logic [127:0] d, input int stall,
                         input string t);
    f2ic_valid   = 1'b1;
    f2ic_paddr   = a;
    mem2ic_ready = (stall == 0);
    #1;
    chk({t, ".miss_rdy"}, ic2f_ready, 0);
    chk({t, ".miss_pkt"}, ic2f_packet, 0);
    chk({t, ".miss_mv"}, ic2mem_valid, 0);
    tick();
    for (int i = 0; i <= stall; i++) begin
      mem2ic_ready = (i == stall);
      #1;
      chk({t, ".req_mv"}, ic2mem_valid, 1);
      chk({t, ".req_addr"}, ic2mem_addr, a);
      chk({t, ".req_rdy"}, ic2f_ready, 0);
      tick();
    end
    mem2ic_ready      = 1'b0;
    mem2ic_data_valid = 1'b1;
    mem2ic_data       = d;
    #1;
    chk({t, ".wait_mv"}, ic2mem_valid, 0);
    chk({t, ".wait_rdy"}, ic2f_ready, 0);
    tick();
    mem2ic_data_valid = 1'b0;
    #1;
    chk({t, ".done_rdy"}, ic2f_ready, 1);
    chk({t, ".done_pkt"}, ic2f_packet, d);
    chk({t, ".done_mv"}, ic2mem_valid, 0);
  endtask

  initial begin
    #2;
    chk("rst.rdy", ic2f_ready, 0);
    chk("rst.pkt", ic2f_packet, 0);
    chk("rst.mv", ic2mem_valid, 0);
    chk("rst.addr", ic2mem_addr, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Cold miss then hit.
    do_fill(28'h0000040, D_A5, 0, "cold");
    tick();
    #1;
    chk("hit.rdy", ic2f_ready, 1);
    chk("hit.pkt", ic2f_packet, D_A5);
    chk("hit.mv", ic2mem_valid, 0);
    tick();

    // Backpressure: 4 refused cycles, request held 5 cycles.
    do_fill(28'h0000041, D_B6, 4, "bp");
    tick();

    // Conflict on index 0: 0x80 evicts 0x40, then 0x40 re-misses.
    do_fill(28'h0000080, D_C7, 0, "conf1");
    tick();
    do_fill(28'h0000040, D_A5, 0, "conf2");
    tick();
    f2ic_paddr = 28'h0000041;
    #1;
    chk("conf.other_hit", ic2f_ready, 1);
    chk("conf.other_pkt", ic2f_packet, D_B6);
    tick();

    // Invalidate during WAIT: line lands invalid and re-misses.
    f2ic_paddr   = 28'h0000042;
    mem2ic_ready = 1'b1;
    tick();
    #1;
    chk("inv.req_mv", ic2mem_valid, 1);
    tick();
    mem2ic_ready = 1'b0;
    ic_inval     = 1'b1;
    #1;
    chk("inv.wait_rdy", ic2f_ready, 0);
    tick();
    ic_inval          = 1'b0;
    mem2ic_data_valid = 1'b1;
    mem2ic_data       = D_D8;
    tick();
    mem2ic_data_valid = 1'b0;
    #1;
    chk("inv.line_rdy", ic2f_ready, 0);
    chk("inv.line_pkt", ic2f_packet, 0);
    tick();
    #1;
    chk("inv.remiss_mv", ic2mem_valid, 1);
    chk("inv.remiss_addr", ic2mem_addr, 28'h0000042);
    mem2ic_ready = 1'b1;
    tick();
    mem2ic_ready      = 1'b0;
    mem2ic_data_valid = 1'b1;
    mem2ic_data       = D_D8;
    tick();
    mem2ic_data_valid = 1'b0;
    #1;
    chk("inv.refill_rdy", ic2f_ready, 1);
    chk("inv.refill_pkt", ic2f_packet, D_D8);
    tick();
    f2ic_paddr = 28'h0000041;
    #1;
    chk("inv.old_line_rdy", ic2f_ready, 0);
    f2ic_valid = 1'b0;
    tick();
    tick();

    // Ready is suppressed in an inval cycle even on a hit.
    do_fill(28'h0000041, D_B6, 0, "refill");
    ic_inval = 1'b1;
    #1;
    chk("ival.rdy", ic2f_ready, 0);
    chk("ival.pkt", ic2f_packet, 0);
    tick();
    ic_inval = 1'b0;
    #1;
    chk("ival.after_rdy", ic2f_ready, 0);
    f2ic_valid = 1'b0;
    tick();
    tick();

    // Reset mid-fill.
    do_fill(28'h0000041, D_B6, 0, "pre_rst");
    tick();
    f2ic_paddr = 28'h0000043;
    tick();
    #1;
    chk("rstmid.req_mv", ic2mem_valid, 1);
    rst = 1'b1;
    #1;
    chk("rstmid.mv_async", ic2mem_valid, 0);
    chk("rstmid.addr_async", ic2mem_addr, 0);
    f2ic_valid = 1'b0;
    tick();
    rst = 1'b0;
    mem2ic_data_valid = 1'b1;
    mem2ic_data       = D_E9;
    tick();
    mem2ic_data_valid = 1'b0;
    #1;
    chk("rstmid.idle_mv", ic2mem_valid, 0);
    f2ic_valid = 1'b1;
    f2ic_paddr = 28'h0000041;
    #1;
    chk("rstmid.prior_rdy", ic2f_ready, 0);
    f2ic_paddr = 28'h0000043;
    #1;
    chk("rstmid.late_rdy", ic2f_ready, 0);
    tick();
    #1;
    chk("rstmid.new_req", ic2mem_valid, 1);
    f2ic_valid = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/mcpu_core_icache.md
# mcpu_core_icache

Direct-mapped, read-only instruction cache: the responder end of the fetch-stage I$ interface. It accepts a 16-byte-packet physical address with a valid strobe and returns the 128-bit instruction packet with a same-cycle ready on a hit. On a miss it fills the line from a single-outstanding memory read port, then answers the still-pending fetch request. It sits between the core fetch stage and the memory arbiter.

## Interface

Parameters:
- SETS_LOG2, 6, log2 of line count (64 lines × 16 B = 1 KiB); tag width = 28 − SETS_LOG2

Ports:
- clkrst_core_clk  input  1  core clock
- clkrst_core_rst  input  1  reset, asynchronous, active-high
- f2ic_valid  input  1  fetch request valid; fetch holds it until served or its address changes on flush
- f2ic_paddr  input  28  packet address (byte address [31:4]); index = [SETS_LOG2−1:0], tag = [27:SETS_LOG2]
- ic2f_ready  output  1  packet valid this cycle for the presented address
- ic2f_packet  output  128  packet data; forced to 0 when ic2f_ready = 0
- ic_inval  input  1  one-cycle pulse; invalidate all lines
- ic2mem_valid  output  1  line read request valid
- ic2mem_addr  output  28  line address of request
- mem2ic_ready  input  1  memory accepts request (handshake on valid & ready)
- mem2ic_data_valid  input  1  fill data returned this cycle
- mem2ic_data  input  128  fill data

## Operation

- Storage: per line a valid bit, tag, 128-bit data, all flops; valid bits reset, tag/data not reset.
- hit = f2ic_valid & valid[index] & (tag[index] == paddr tag) & state == IDLE & !ic_inval.
- ic2f_ready = hit (combinational from f2ic_paddr/f2ic_valid); ic2f_packet = hit ? data[index] : 0.
- States:
  - IDLE: if f2ic_valid & !hit & !ic_inval → latch paddr into fill_addr, go REQ.
  - REQ: ic2mem_valid = 1, ic2mem_addr = fill_addr (stable); on mem2ic_ready → WAIT. mem2ic_data_valid is never asserted in REQ.
  - WAIT: on mem2ic_data_valid → write data/tag to line fill_addr index, set valid, go IDLE.
- Fill always completes even if f2ic_paddr changes or f2ic_valid drops mid-fill; after returning to IDLE the current address is looked up afresh (may re-miss).
- Conflicting line (same index, different tag) is simply overwritten.
- ic_inval: clears every valid bit at the next edge. Arriving in REQ/WAIT sets a drop flag; the fill still runs to completion but the line is written with valid = 0. Inval coincident with fill write: inval wins (line ends invalid). ic2f_ready is 0 in the inval cycle.
- ic2f_ready is never asserted outside IDLE.

## Timing

- Reset values: ic2f_ready 0, ic2f_packet 0, ic2mem_valid 0, ic2mem_addr 0, state IDLE, all valid bits 0, drop flag 0.
- Reset asserted mid-fill: immediately returns to IDLE, request dropped, all lines invalid; any late mem2ic_data_valid after reset is ignored (memory side is reset together).
- Hit latency: 0 cycles (ready in the cycle the address is presented).
- Miss, memory accepts immediately and returns data in the acceptance+1 cycle: miss at cycle N, ic2mem_valid at N+1, data at N+2, ic2f_ready at N+3.
- Each extra mem2ic_ready stall or data delay cycle adds one cycle.
- One outstanding memory request maximum; ic2mem_valid deasserts the cycle after acceptance.

## Test plan

- Cold miss: reset, f2ic_valid=1, paddr=0x0000040; mem ready immediately, data 0x...A5 one cycle later → ic2mem_addr=0x0000040 at cycle 1, ic2f_ready=1 with packet 0x...A5 at cycle 3; ready was 0 in cycles 0–2 with packet 0.
- Hit after fill: present 0x0000040 again → ready same cycle, no ic2mem_valid.
- Backpressure: mem2ic_ready low 4 cycles → ic2mem_valid and ic2mem_addr held stable 5 cycles; ready 4 cycles later than cold-miss case.
- Conflict: fill 0x0000040 then 0x0000080 (same index at SETS_LOG2=6) → second misses and evicts; re-request of 0x0000040 misses again.
- Invalidate during fill: ic_inval pulse in WAIT → fill completes, line not valid, immediate re-miss and second request issued for the same address; all previously valid lines miss.
- Reset mid-fill: assert clkrst_core_rst in REQ → ic2mem_valid 0 asynchronously, state IDLE, subsequent request of prior-hit address misses.
